// File: rtl/memory_access_unit_if.sv
// Data-memory port between the memory-stage access unit and the memory.
interface memory_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [BE_WIDTH-1:0]   mem_be_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  // Access unit side: issues requests, receives completion.
  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ack_i, mem_rdata_i
  );

  // Memory side: accepts requests, returns completion.
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: turns a load or store into a req/ack
// transaction, stalls the pipeline until completion, aligns and extends
// load data, and flags misaligned accesses and bus timeouts.
module memory_access_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic [2:0]            funct3M_i,
  input  logic [DATA_WIDTH-1:0] ALU_outM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  output logic                  StallM_o,
  output logic                  MisalignM_o,
  output logic                  BusErrM_o,
  memory_access_unit_if.master  mem
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  state_t                nextState;
  logic                  access;
  logic                  aligned;
  logic                  isByte;
  logic                  isHalf;
  logic [1:0]            off;
  logic                  launch;
  logic                  timeoutHit;
  logic [3:0]            beNext;
  logic [DATA_WIDTH-1:0] wdataNext;
  logic [2:0]            ldFunct3;
  logic [1:0]            ldOff;
  logic [CNT_W-1:0]      timeoutCnt;
  logic [7:0]            ldByte;
  logic [15:0]           ldHalf;
  logic [DATA_WIDTH-1:0] loadData;

  // Decode access size and alignment of the instruction in the memory stage
  always_comb begin
    access = MemReadM_i | MemWriteM_i;
    off    = ALU_outM_i[1:0];
    isByte = (funct3M_i[1:0] == 2'b00);
    isHalf = (funct3M_i[1:0] == 2'b01);
    if (isByte) begin
      aligned = 1'b1;
    end else if (isHalf) begin
      aligned = ~off[0];
    end else begin
      aligned = (off == 2'b00);
    end
  end

  // Byte enables and lane-replicated store data for the pending access
  always_comb begin
    if (isByte) begin
      beNext    = 4'b0001 << off;
      wdataNext = {4{WriteDataM_i[7:0]}};
    end else if (isHalf) begin
      beNext    = off[1] ? 4'b1100 : 4'b0011;
      wdataNext = {2{WriteDataM_i[15:0]}};
    end else begin
      beNext    = 4'b1111;
      wdataNext = WriteDataM_i;
    end
  end

  assign launch     = (state == IDLE) & access & aligned;
  assign timeoutHit = (state == BUSY) & ~mem.mem_ack_i & (timeoutCnt == CNT_LAST);

  // Select and extend the addressed lane of the returned read word
  always_comb begin
    ldByte = mem.mem_rdata_i[{ldOff, 3'b000} +: 8];
    ldHalf = mem.mem_rdata_i[{ldOff[1], 4'b0000} +: 16];
    case (ldFunct3[1:0])
      2'b00:   loadData = ldFunct3[2] ? {24'b0, ldByte} : {{24{ldByte[7]}}, ldByte};
      2'b01:   loadData = ldFunct3[2] ? {16'b0, ldHalf} : {{16{ldHalf[15]}}, ldHalf};
      default: loadData = mem.mem_rdata_i;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state, stall and misalign decode
  always_comb begin
    nextState   = state;
    StallM_o    = 1'b0;
    MisalignM_o = 1'b0;
    case (state)
      IDLE: begin
        StallM_o    = access & aligned;
        MisalignM_o = access & ~aligned;
        if (access && aligned) nextState = BUSY;
      end
      BUSY: begin
        StallM_o = 1'b1;
        if (mem.mem_ack_i || timeoutHit) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request, load-result, timeout counter and bus-error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_wdata_o <= '0;
      mem.mem_be_o    <= 4'b0000;
      ReadDataM_o     <= '0;
      BusErrM_o       <= 1'b0;
      ldFunct3        <= 3'b000;
      ldOff           <= 2'b00;
      timeoutCnt      <= '0;
    end else begin
      BusErrM_o <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            mem.mem_req_o   <= 1'b1;
            mem.mem_we_o    <= MemWriteM_i;
            mem.mem_addr_o  <= {ALU_outM_i[DATA_WIDTH-1:2], 2'b00};
            mem.mem_be_o    <= beNext;
            mem.mem_wdata_o <= wdataNext;
            ldFunct3        <= funct3M_i;
            ldOff           <= off;
            timeoutCnt      <= '0;
          end
        end
        BUSY: begin
          if (mem.mem_ack_i) begin
            mem.mem_req_o <= 1'b0;
            if (!mem.mem_we_o) ReadDataM_o <= loadData;
          end else begin
            timeoutCnt <= timeoutCnt + CNT_W'(1);
            if (timeoutHit) begin
              mem.mem_req_o <= 1'b0;
              ReadDataM_o   <= '0;
              BusErrM_o     <= 1'b1;
            end
          end
        end
        DONE:    timeoutCnt <= '0;
        default: timeoutCnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: directed loads/stores, a
// memory responder with programmable ack delay, and a monitor that checks
// bus fields while requesting and results on every completion.
module tb_memory_access_unit;

  localparam int unsigned TO = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM_i;
  logic        MemWriteM_i;
  logic [2:0]  funct3M_i;
  logic [31:0] ALU_outM_i;
  logic [31:0] WriteDataM_i;
  logic [31:0] ReadDataM_o;
  logic        StallM_o;
  logic        MisalignM_o;
  logic        BusErrM_o;

  memory_access_unit_if #(.DATA_WIDTH(32)) mem ();

  memory_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemReadM_i   (MemReadM_i),
    .MemWriteM_i  (MemWriteM_i),
    .funct3M_i    (funct3M_i),
    .ALU_outM_i   (ALU_outM_i),
    .WriteDataM_i (WriteDataM_i),
    .ReadDataM_o  (ReadDataM_o),
    .StallM_o     (StallM_o),
    .MisalignM_o  (MisalignM_o),
    .BusErrM_o    (BusErrM_o),
    .mem          (mem)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  int          ackDelay = 1;
  logic [31:0] rspData  = 32'h0;
  logic [31:0] curRead  = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, want);
    end
  endtask

  // Memory responder: ack after ackDelay BUSY cycles (0 = never ack)
  int busyCnt = 0;
  always @(negedge clk) begin
    if (rst || !mem.mem_req_o) begin
      busyCnt       = 0;
      mem.mem_ack_i = 1'b0;
    end else begin
      busyCnt++;
      mem.mem_ack_i = (ackDelay > 0) && (busyCnt == ackDelay);
    end
    mem.mem_rdata_i = rspData;
  end

  // An abandoned transaction never completes
  always @(posedge rst) sb.delete();

  // Monitor: bus fields while requesting, results on each completion
  logic prevStall = 1'b0;
  int   stallCnt  = 0;
  logic errCheck  = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
      stallCnt  = 0;
      errCheck  = 1'b0;
    end else begin
      if (errCheck) begin
        chk("buserr_one_cycle", 32'(BusErrM_o), 32'd0);
        errCheck = 1'b0;
      end
      if (mem.mem_req_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_req", 32'(mem.mem_req_o), 32'd0);
        end else begin
          chk("addr",  mem.mem_addr_o,       sb[0].addr);
          chk("be",    32'(mem.mem_be_o),    32'(sb[0].be));
          chk("we",    32'(mem.mem_we_o),    32'(sb[0].we));
          chk("wdata", mem.mem_wdata_o,      sb[0].wdata);
        end
      end
      if (StallM_o) begin
        stallCnt++;
      end else if (prevStall) begin
        chk("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          me = sb.pop_front();
          chk("read_data",    ReadDataM_o,       me.rdata);
          chk("bus_err",      32'(BusErrM_o),    32'(me.err));
          chk("stall_cycles", 32'(stallCnt),     32'(me.stall));
          chk("req_in_done",  32'(mem.mem_req_o), 32'd0);
          if (me.err) errCheck = 1'b1;
        end
        stallCnt = 0;
      end
      prevStall = StallM_o;
    end
  end

  task automatic idleInputs();
    MemReadM_i   = 1'b0;
    MemWriteM_i  = 1'b0;
    funct3M_i    = 3'b000;
    ALU_outM_i   = 32'h0;
    WriteDataM_i = 32'h0;
  endtask

  // One aligned access; entered and left at posedge+1
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rsp, input int delay,
                     input logic [31:0] expRead, input logic expErr,
                     input logic [3:0] expBe, input logic [31:0] expWdata);
    exp_t e;
    logic seen;
    logic done;
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = expWdata;
    e.be    = expBe;
    e.we    = wr;
    e.rdata = expRead;
    e.err   = expErr;
    e.stall = (delay == 0) ? int'(TO) + 1 : delay + 1;
    sb.push_back(e);
    curRead      = expRead;
    ackDelay     = delay;
    rspData      = rsp;
    MemReadM_i   = rd;
    MemWriteM_i  = wr;
    funct3M_i    = f3;
    ALU_outM_i   = addr;
    WriteDataM_i = wd;
    seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (StallM_o) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    chk("txn_completes", 32'(done), 32'd1);
    @(posedge clk);
    #1 idleInputs();
  endtask

  // Misaligned access: no request, no stall, result untouched
  task automatic misalign(input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input string nm);
    MemReadM_i   = ~wr;
    MemWriteM_i  = wr;
    funct3M_i    = f3;
    ALU_outM_i   = addr;
    WriteDataM_i = 32'h5A5A5A5A;
    repeat (2) begin
      @(negedge clk);
      chk({nm, "_misalign"}, 32'(MisalignM_o),  32'd1);
      chk({nm, "_stall"},    32'(StallM_o),     32'd0);
      chk({nm, "_req"},      32'(mem.mem_req_o), 32'd0);
      chk({nm, "_rdata"},    ReadDataM_o,       curRead);
      @(posedge clk);
      #1;
    end
    idleInputs();
    @(negedge clk);
    chk({nm, "_misalign_clear"}, 32'(MisalignM_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(mem.mem_req_o), 32'd0);
    chk("rst_we",    32'(mem.mem_we_o),  32'd0);
    chk("rst_addr",  mem.mem_addr_o,     32'd0);
    chk("rst_wdata", mem.mem_wdata_o,    32'd0);
    chk("rst_be",    32'(mem.mem_be_o),  32'd0);
    chk("rst_rdata", ReadDataM_o,        32'd0);
    chk("rst_buserr",32'(BusErrM_o),     32'd0);
    chk("rst_stall", 32'(StallM_o),      32'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Loads: word, byte/half with sign and zero extension
    run(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 4'b1111, 32'h0);
    run(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 32'hFFFFFF80, 0, 4'b1000, 32'h0);
    run(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, 32'h00000080, 0, 4'b1000, 32'h0);
    run(1, 0, 3'b001, 32'h102, 32'h0, 32'h80112233, 1, 32'hFFFF8011, 0, 4'b1100, 32'h0);

    // Reset in the second BUSY cycle abandons the load
    sb.push_back('{addr: 32'h180, wdata: 32'h0, be: 4'b1111, we: 1'b0,
                   rdata: 32'h0, err: 1'b0, stall: 0});
    ackDelay    = 0;
    MemReadM_i  = 1'b1;
    funct3M_i   = 3'b010;
    ALU_outM_i  = 32'h180;
    @(posedge clk);
    @(posedge clk);
    #1 chk("pre_rst_req", 32'(mem.mem_req_o), 32'd1);
    #1 rst = 1'b1;
    #1 chk("midrst_req",   32'(mem.mem_req_o), 32'd0);
    chk("midrst_rdata", ReadDataM_o, 32'd0);
    idleInputs();
    #1 chk("midrst_stall", 32'(StallM_o), 32'd0);
    curRead = 32'h0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    run(1, 0, 3'b101, 32'h100, 32'h0, 32'h80112233, 2, 32'h00002233, 0, 4'b0011, 32'h0);

    // Stores leave the load result untouched
    run(0, 1, 3'b000, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 3, 32'h00002233, 0, 4'b0010, 32'hABABABAB);
    run(0, 1, 3'b001, 32'h202, 32'h1234CDEF, 32'hFFFFFFFF, 1, 32'h00002233, 0, 4'b1100, 32'hCDEFCDEF);
    run(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 2, 32'h00002233, 0, 4'b1111, 32'hCAFEF00D);
    // Read and write together: the write wins
    run(1, 1, 3'b010, 32'h208, 32'h11223344, 32'hFFFFFFFF, 1, 32'h00002233, 0, 4'b1111, 32'h11223344);
    // Undefined funct3 behaves as a word access
    run(1, 0, 3'b011, 32'h10C, 32'h0, 32'h55AA55AA, 1, 32'h55AA55AA, 0, 4'b1111, 32'h0);
    run(1, 0, 3'b000, 32'h101, 32'h0, 32'h80112233, 1, 32'h00000022, 0, 4'b0010, 32'h0);

    misalign(1'b0, 3'b010, 32'h102, "lw_0x102");
    misalign(1'b1, 3'b001, 32'h203, "sh_0x203");

    // No ack: timeout after TO BUSY cycles
    run(1, 0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, 32'h0, 1, 4'b1111, 32'h0);
    run(1, 0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 1, 32'h0BADF00D, 0, 4'b1111, 32'h0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
